fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that sits directly upstream of `decoder_control`. It owns the fetch PC and issues word requests to instruction memory over a valid/ready request channel. Returned words are buffered in order in a small FIFO, and each buffered word is presented as `insn` with its `insn_pc` to the decode stage. It handles redirects from branches and jumps, discards stale in-flight responses, and stops fetching on halt (ebreak).

## Interface
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset; bits [1:0] must be 0.
- `DEPTH`, default 4: instruction FIFO entries; power of two, ≥2.
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset. Asynchronous and active-high.
- `imem_req_valid`, out, 1: fetch request valid.
- `imem_req_ready`, in, 1: memory accepts the request this cycle.
- `imem_req_addr`, out, 32: word-aligned fetch address.
- `imem_resp_valid`, in, 1: response word valid. The response channel has no backpressure. Responses return in request order, at least 1 cycle after acceptance.
- `imem_resp_data`, in, 32: fetched instruction word.
- `insn_valid`, out, 1: FIFO head is valid.
- `insn_ready`, in, 1: decode consumes the head this cycle.
- `insn`, out, 32: head instruction; drives the decoder `insn` input.
- `insn_pc`, out, 32: address of the head instruction.
- `redirect_valid`, in, 1: taken branch, jal or jalr.
- `redirect_pc`, in, 32: target address; bits [1:0] are ignored and treated as 0.
- `halt`, in, 1: level signal driven by ebreak_hit; suppresses new requests.

## Operation
- **State**
  - `fetch_pc`: 32 bits.
  - `outstanding`: count of accepted requests whose response has not yet arrived.
  - `drop_cnt`: count of in-flight responses to discard.
  - FIFO of {pc, insn} pairs, `DEPTH` entries.
- **Issue rule**
  - `imem_req_valid = !halt && !redirect_valid && (outstanding + fifo_count < DEPTH)`.
  - The issue rule uses only registered counts, so no slot is ever overcommitted and responses can never overflow the FIFO.
  - `imem_req_addr = fetch_pc`.
  - When a request fires (valid && ready): `fetch_pc += 4` and `outstanding++`.
- **Response handling**
  - When `imem_resp_valid` is high: `outstanding--`.
  - If `drop_cnt > 0`, the word is discarded and `drop_cnt--`.
  - Otherwise, {pc, word} is pushed into the FIFO. The pc is tracked by a separate `resp_pc` register that advances by 4 per accepted, non-dropped response.
- **Dequeue**
  - The head is popped when `insn_valid && insn_ready`.
- **Redirect** (takes precedence over every other update that cycle)
  - The FIFO is flushed. A same-cycle pop is treated as completed, because the consuming instruction is the one causing the redirect.
  - `fetch_pc` and `resp_pc` are set to `redirect_pc & ~3`.
  - `drop_cnt` is set to `outstanding`, adjusted as follows: −1 if a response arrives this cycle. No request can fire in a redirect cycle because `imem_req_valid` is low.
  - A redirect while `drop_cnt > 0` still sets `drop_cnt` to the recomputed total in-flight count; no stale word may ever reach `insn`.
- **Halt**
  - Blocks issue only. Outstanding responses are still accepted or dropped, and the FIFO still drains.
  - Deasserting halt resumes fetch at `fetch_pc`.
- **Reset mid-operation** clears all state immediately. Responses arriving after `rst` deasserts that belong to requests made before reset are the memory's responsibility: the memory must be reset by the same `rst`.

## Timing
- **Reset values:**
  - `imem_req_valid` = 0 while `rst` is high.
  - `imem_req_addr` = `RESET_PC`.
  - `insn_valid` = 0, `insn` = 0, `insn_pc` = 0.
  - `outstanding`, `drop_cnt` and the FIFO count are all 0.
- **First request:** `imem_req_valid` is 1 in the first cycle after `rst` deasserts, provided `halt` = 0.
- **FIFO write latency:** a response arriving in cycle t gives `insn_valid` in cycle t+1. The FIFO is registered with no response-to-output bypass.
- **Redirect latency:** `redirect_valid` in cycle t gives a request for the target in cycle t+1. With 1-cycle memory, the target reaches `insn_valid` in cycle t+3.
- **Throughput:** with `DEPTH` = 4 and 1-cycle memory and `insn_ready` held high, the block sustains 1 instruction per cycle.
- **Simultaneous push and pop on a full FIFO:** cannot occur by construction (see the issue rule). On a non-full FIFO, both happen and the count is unchanged.
- **`outstanding` width:** `$clog2(DEPTH)+1` bits. It never exceeds `DEPTH`.

## Structure
- Shared header `riscv_defs.vh` holds:
  - `INSN_BYTES` = 4.
  - the default `RESET_PC`.
  - the NOP encoding `32'h0000_0013`, for benches.
- Sub-module `fetch_fifo`: synchronous FIFO with ports `push`, `pop` and `flush`, parameterised by width and `DEPTH`. It exposes `count`, `empty` and `full`. Flush has priority over push.
- Remaining logic (PC, counters, issue rule) lives in `fetch_unit`.

## Test plan
- **Reset and sequential fetch:** `RESET_PC` = `0x100`, 1-cycle memory, `insn_ready` = 1.
  - Requests go to `0x100, 0x104, 0x108…` in consecutive cycles.
  - `insn_pc` shows `0x100` at cycle 2, followed by one instruction per cycle.
- **Backpressure:** `insn_ready` = 0 for 10 cycles.
  - Exactly 4 words are buffered and `imem_req_valid` drops.
  - On releasing `insn_ready`, the order is preserved and no word is duplicated.
- **Redirect with in-flight responses:** 3-cycle memory, 2 requests outstanding, `redirect_valid` with `redirect_pc` = `0x200`.
  - Both stale responses are dropped.
  - The next `insn_pc` is `0x200`.
- **Redirect concurrent with pop and response arrival, then a second redirect to `0x300` while `drop_cnt` = 1.**
  - No word from `0x1xx` or `0x200` reaches `insn`.
  - The first delivered instruction is `0x300`.
- **Halt:** assert `halt` with 2 requests outstanding.
  - No new requests are issued.
  - Both words are delivered.
  - Deasserting `halt` resumes fetch at the next sequential PC.
- **Asynchronous reset mid-stream:** assert `rst` between clock edges.
  - `insn_valid` and `imem_req_valid` go to 0 immediately.
  - After release, fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared constants and types for the instruction fetch stage.
//   INSN_BYTES        - byte stride between sequential instructions
//   DEFAULT_RESET_PC  - default first fetch address after reset
//   NOP_INSN          - canonical NOP encoding (addi x0, x0, 0)
//   fetch_entry_t     - {pc, insn} pair held in the instruction FIFO
//   word_align()      - clears the byte-offset bits of an address
package fetch_unit_pkg;

  localparam int unsigned INSN_BYTES       = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSN         = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous circular-buffer FIFO holding fetched instructions.
//   clk, rst      - clock, asynchronous active-high reset (pointers/count only)
//   push, wdata   - write one entry (ignored when full or when flushing)
//   pop           - consume the head entry (ignored when empty)
//   flush         - discard all entries; wins over push and pop
//   rdata         - head entry (meaningful only when !empty)
//   count, empty, full - occupancy status
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [CW-1:0]     count,
  output logic              empty,
  output logic              full
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decoder.
//   RESET_PC, DEPTH            - first fetch address; FIFO entries (power of two, >= 2)
//   clk, rst                   - clock, asynchronous active-high reset
//   imem_req_valid/ready/addr  - word request channel to instruction memory
//   imem_resp_valid/data       - in-order response channel, no backpressure
//   insn_valid/ready, insn, insn_pc - buffered instruction presented to decode
//   redirect_valid, redirect_pc - taken branch / jump target
//   halt                       - blocks new requests while high
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        insn_valid,
  input  logic        insn_ready,
  output logic [31:0] insn,
  output logic [31:0] insn_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]  fetch_pc;
  logic [31:0]  resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   inflight_total;
  logic          fifo_empty;
  logic          fifo_full;
  logic          req_fire;
  logic          fifo_push;
  logic          fifo_pop;
  logic [31:0]   redirect_tgt;
  logic [CW-1:0] outstanding_after_resp;
  fetch_entry_t  wr_entry;
  fetch_entry_t  head;

  // Only registered counts feed the issue decision: every accepted request
  // already owns a FIFO slot, so a response can never find the FIFO full.
  assign inflight_total = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req_valid = !rst && !halt && !redirect_valid
                          && (inflight_total < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign redirect_tgt           = word_align(redirect_pc);
  assign outstanding_after_resp = outstanding - CW'(imem_resp_valid);

  assign fifo_push = imem_resp_valid && (drop_cnt == '0) && !fifo_full;
  assign fifo_pop  = insn_valid && insn_ready;
  assign wr_entry  = '{pc: resp_pc, insn: imem_resp_data};

  fetch_fifo #(
    .DATA_W ($bits(fetch_entry_t)),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (redirect_valid),
    .wdata (wr_entry),
    .rdata (head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Gate the head so decode sees zeros whenever nothing is buffered.
  assign insn_valid = !fifo_empty;
  assign insn       = fifo_empty ? '0 : head.insn;
  assign insn_pc    = fifo_empty ? '0 : head.pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight after this cycle's response is stale,
      // including words already scheduled for dropping.
      fetch_pc    <= redirect_tgt;
      resp_pc     <= redirect_tgt;
      outstanding <= outstanding_after_resp;
      drop_cnt    <= outstanding_after_resp;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + 32'(INSN_BYTES);
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_resp_valid);
      if (imem_resp_valid) begin
        if (drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
        else                resp_pc  <= resp_pc + 32'(INSN_BYTES);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit (RESET_PC = 0x100, DEPTH = 4).
// An in-order memory model answers requests after a configurable latency; the
// architectural reference is the expected instruction stream: sequential from
// RESET_PC, restarting at the aligned target after every redirect.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] RPC   = 32'h0000_0100;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = NOP_INSN;
  logic        insn_valid;
  logic        insn_ready = 1'b1;
  logic [31:0] insn;
  logic [31:0] insn_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt = 1'b0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .insn_valid      (insn_valid),
    .insn_ready      (insn_ready),
    .insn            (insn),
    .insn_pc         (insn_pc),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .halt            (halt)
  );

  int checks = 0;
  int errors = 0;

  // Memory model: in-order queue of accepted addresses with due cycles.
  logic [31:0] q_addr[$];
  int          q_due[$];
  int          cycnum;
  int          lat_min = 1;
  int          lat_max = 1;
  logic [31:0] exp_req;
  logic [31:0] exp_pc;
  int          pops;
  bit          at_neg;

  logic        d_insn_ready = 1'b1;
  logic        d_req_ready  = 1'b1;
  logic        d_redirect   = 1'b0;
  logic        d_halt       = 1'b0;
  logic [31:0] d_redirect_pc = '0;

  typedef struct {
    logic        rdy;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        iv;
    logic [31:0] ipc;
  } vec_t;
  vec_t tbl[21];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h (cycle %0d)", name, got, exp, cycnum);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b expected=%b (cycle %0d)", name, got, exp, cycnum);
    end
  endtask

  // Apply one cycle of inputs, then score the events of the coming edge.
  task automatic cyc();
    if (!at_neg) @(negedge clk);
    at_neg = 1'b0;
    cycnum++;
    insn_ready     = d_insn_ready;
    imem_req_ready = d_req_ready;
    redirect_valid = d_redirect;
    redirect_pc    = d_redirect_pc;
    halt           = d_halt;
    if (q_due.size() > 0 && q_due[0] <= cycnum) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(q_addr[0]);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = NOP_INSN;
    end
    #1;
    if (halt || redirect_valid) chk1("req_blocked", imem_req_valid, 1'b0);
    if (insn_valid && insn_ready) begin
      chk("deliver_pc", insn_pc, exp_pc);
      chk("deliver_insn", insn, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    if (imem_resp_valid) begin
      q_addr.delete(0);
      q_due.delete(0);
    end
    if (imem_req_valid && imem_req_ready) begin
      chk("req_addr", imem_req_addr, exp_req);
      q_addr.push_back(imem_req_addr);
      q_due.push_back(cycnum + int'($urandom_range(lat_max, lat_min)));
      exp_req = exp_req + 32'd4;
      chk1("inflight_le_depth", q_addr.size() <= DEPTH, 1'b1);
    end
    if (redirect_valid) begin
      exp_req = redirect_pc & ~32'h3;
      exp_pc  = redirect_pc & ~32'h3;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q_addr.delete();
    q_due.delete();
    redirect_valid  = 1'b0;
    halt            = 1'b0;
    imem_resp_valid = 1'b0;
    imem_req_ready  = 1'b1;
    insn_ready      = 1'b1;
    d_redirect      = 1'b0;
    d_halt          = 1'b0;
    d_insn_ready    = 1'b1;
    d_req_ready     = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk1("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_req_addr", imem_req_addr, RPC);
    chk1("rst_insn_valid", insn_valid, 1'b0);
    chk("rst_insn", insn, 32'h0);
    chk("rst_insn_pc", insn_pc, 32'h0);
    rst     = 1'b0;
    cycnum  = -1;
    exp_req = RPC;
    exp_pc  = RPC;
    pops    = 0;
    at_neg  = 1'b1;
  endtask

  task automatic wait_valid(input string name, input int budget, input logic [31:0] exp);
    int n = 0;
    do begin
      cyc();
      n++;
    end while (!insn_valid && n < budget);
    chk1({name, "_arrived"}, insn_valid, 1'b1);
    if (insn_valid) chk(name, insn_pc, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Sequential fetch then 10 cycles of backpressure, 1-cycle memory.
    tbl[0]  = '{1'b1, 1'b1, 32'h100, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b1, 32'h104, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b1, 32'h108, 1'b1, 32'h100};
    tbl[3]  = '{1'b1, 1'b1, 32'h10C, 1'b1, 32'h104};
    tbl[4]  = '{1'b1, 1'b1, 32'h110, 1'b1, 32'h108};
    tbl[5]  = '{1'b0, 1'b1, 32'h114, 1'b1, 32'h10C};
    tbl[6]  = '{1'b0, 1'b1, 32'h118, 1'b1, 32'h10C};
    tbl[7]  = '{1'b0, 1'b0, 32'h11C, 1'b1, 32'h10C};
    for (int i = 8; i <= 14; i++) tbl[i] = '{1'b0, 1'b0, 32'h11C, 1'b1, 32'h10C};
    tbl[15] = '{1'b1, 1'b0, 32'h11C, 1'b1, 32'h10C};
    tbl[16] = '{1'b1, 1'b1, 32'h11C, 1'b1, 32'h110};
    tbl[17] = '{1'b1, 1'b1, 32'h120, 1'b1, 32'h114};
    tbl[18] = '{1'b1, 1'b1, 32'h124, 1'b1, 32'h118};
    tbl[19] = '{1'b1, 1'b1, 32'h128, 1'b1, 32'h11C};
    tbl[20] = '{1'b1, 1'b1, 32'h12C, 1'b1, 32'h120};

    lat_min = 1; lat_max = 1;
    do_reset();
    for (int i = 0; i < 21; i++) begin
      d_insn_ready = tbl[i].rdy;
      cyc();
      chk1($sformatf("tbl%0d_req_valid", i), imem_req_valid, tbl[i].req_valid);
      chk($sformatf("tbl%0d_req_addr", i), imem_req_addr, tbl[i].req_addr);
      chk1($sformatf("tbl%0d_insn_valid", i), insn_valid, tbl[i].iv);
      if (tbl[i].iv) chk($sformatf("tbl%0d_insn_pc", i), insn_pc, tbl[i].ipc);
    end

    // Redirect with two requests in flight, 3-cycle memory.
    lat_min = 3; lat_max = 3;
    do_reset();
    cyc();
    cyc();
    d_redirect = 1'b1; d_redirect_pc = 32'h0000_0202;
    cyc();
    d_redirect = 1'b0;
    cyc();
    chk1("redir_req_valid", imem_req_valid, 1'b1);
    chk("redir_req_addr", imem_req_addr, 32'h200);
    wait_valid("redir_first_pc", 20, 32'h200);

    // Redirect together with pop and response, then re-redirect while dropping.
    do_reset();
    repeat (4) cyc();
    d_redirect = 1'b1; d_redirect_pc = 32'h200;
    cyc();
    chk1("redir_pop_valid", insn_valid, 1'b1);
    chk("redir_pop_pc", insn_pc, 32'h100);
    d_redirect = 1'b0;
    cyc();
    chk1("redir_tgt1_req", imem_req_valid, 1'b1);
    chk("redir_tgt1_addr", imem_req_addr, 32'h200);
    d_redirect = 1'b1; d_redirect_pc = 32'h0000_0301;
    cyc();
    d_redirect = 1'b0;
    cyc();
    chk1("redir_tgt2_req", imem_req_valid, 1'b1);
    chk("redir_tgt2_addr", imem_req_addr, 32'h300);
    wait_valid("redir2_first_pc", 20, 32'h300);

    // Halt with two requests outstanding.
    do_reset();
    cyc();
    cyc();
    d_halt = 1'b1;
    repeat (10) begin
      cyc();
      chk1("halt_no_req", imem_req_valid, 1'b0);
    end
    chk("halt_delivered", 32'(pops), 32'd2);
    d_halt = 1'b0;
    cyc();
    chk1("halt_resume_valid", imem_req_valid, 1'b1);
    chk("halt_resume_addr", imem_req_addr, 32'h108);

    // Asynchronous reset in the middle of a clock period.
    lat_min = 1; lat_max = 1;
    do_reset();
    d_insn_ready = 1'b0;
    repeat (6) cyc();
    chk1("pre_rst_valid", insn_valid, 1'b1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk1("async_rst_insn_valid", insn_valid, 1'b0);
    chk1("async_rst_req_valid", imem_req_valid, 1'b0);
    do_reset();
    cyc();
    chk1("restart_req_valid", imem_req_valid, 1'b1);
    chk("restart_req_addr", imem_req_addr, RPC);
    wait_valid("restart_first_pc", 10, RPC);

    // Randomized traffic against the stream reference.
    lat_min = 1; lat_max = 4;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      d_req_ready   = ($urandom_range(0, 3) != 0);
      d_insn_ready  = ($urandom_range(0, 9) < 7);
      d_redirect    = ($urandom_range(0, 19) == 0);
      d_redirect_pc = 32'h100 + ($urandom & 32'h3FF);
      if ($urandom_range(0, 19) == 0) d_halt = !d_halt;
      cyc();
    end
    d_redirect = 1'b0; d_halt = 1'b0; d_insn_ready = 1'b1; d_req_ready = 1'b1;
    repeat (20) cyc();
    chk1("random_progress", pops > 300, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
